elevator_call_scheduler: RTL

- Producer end of the elevator controller's `requested_floor` interface.
- Latches hall/car call buttons into a pending-request register and picks the next target floor by SCAN order (keep direction while requests remain ahead).
- Drives `requested_floor` to the elevator state machine and watches `current_floor` and `idle_display` to detect arrival.
- On arrival it holds the door open for a dwell period and clears the served request.

---
 rtl/elevator_call_scheduler.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/elevator_call_scheduler.sv
// elevator_call_scheduler: latches hall/car call buttons into pending requests
// and feeds the elevator controller its next target floor in SCAN order.
module elevator_call_scheduler #(
  parameter int          NUM_FLOORS  = 8,
  parameter logic [31:0] DWELL_COUNT = 32'd10000000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_FLOORS-1:0] call_btn,
  input  logic [3:0]            current_floor,
  input  logic                  idle,
  output logic [3:0]            requested_floor,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  door_open,
  output logic                  dir_up
);

  typedef enum logic [1:0] {WAIT, MOVE, DWELL} state_t;

  localparam logic [4:0] FLOORS5    = 5'(NUM_FLOORS);
  localparam logic [3:0] LAST_FLOOR = 4'(NUM_FLOORS - 1);

  state_t                r_state;
  logic [31:0]           r_count;
  logic [NUM_FLOORS-1:0] r_sync1;
  logic [NUM_FLOORS-1:0] r_sync2;
  logic [NUM_FLOORS-1:0] r_prev;

  logic                  w_cfValid;
  logic [3:0]            w_floor;
  logic [NUM_FLOORS-1:0] w_cfMask;
  logic [NUM_FLOORS-1:0] w_rise;
  logic [NUM_FLOORS-1:0] w_set;
  logic [NUM_FLOORS-1:0] w_clr;
  logic                  w_atFloor;
  logic                  w_enterDwell;
  logic                  w_restart;
  logic                  w_dwellDone;
  logic                  w_hasAbove;
  logic                  w_hasBelow;
  logic [3:0]            w_above;
  logic [3:0]            w_below;
  logic [3:0]            w_target;
  logic                  w_nextDir;

  // Out-of-range floors never match a request but still steer as the top floor.
  assign w_cfValid = ({1'b0, current_floor} < FLOORS5);
  assign w_floor   = w_cfValid ? current_floor : LAST_FLOOR;

  always_comb begin
    w_cfMask = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      w_cfMask[i] = w_cfValid && (current_floor == 4'(i));
    end
  end

  assign w_rise       = r_sync2 & ~r_prev;
  assign w_atFloor    = |(pending & w_cfMask);
  assign w_enterDwell = ((r_state == WAIT) && w_atFloor) ||
                        ((r_state == MOVE) && idle && (current_floor == requested_floor) && w_atFloor);
  assign w_restart    = (r_state == DWELL) && |(w_rise & w_cfMask);
  assign w_dwellDone  = (r_state == DWELL) && !w_restart && (r_count == DWELL_COUNT - 32'd1);
  assign w_clr        = w_enterDwell ? w_cfMask : '0;
  assign w_set        = w_rise & ~((r_state == DWELL) ? w_cfMask : '0);

  // Descending scan leaves the nearest floor above; ascending the nearest below.
  always_comb begin
    w_hasAbove = 1'b0;
    w_above    = w_floor;
    w_hasBelow = 1'b0;
    w_below    = w_floor;
    for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
      if (pending[i] && (4'(i) > w_floor)) begin
        w_hasAbove = 1'b1;
        w_above    = 4'(i);
      end
    end
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (pending[i] && (4'(i) < w_floor)) begin
        w_hasBelow = 1'b1;
        w_below    = 4'(i);
      end
    end
  end

  always_comb begin
    w_target  = w_floor;
    w_nextDir = dir_up;
    if (dir_up) begin
      if (w_hasAbove) begin
        w_target = w_above;
      end else if (w_hasBelow) begin
        w_target  = w_below;
        w_nextDir = 1'b0;
      end
    end else begin
      if (w_hasBelow) begin
        w_target = w_below;
      end else if (w_hasAbove) begin
        w_target  = w_above;
        w_nextDir = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_prev  <= '0;
      pending <= '0;
    end else begin
      r_sync1 <= call_btn;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      pending <= (pending | w_set) & ~w_clr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= WAIT;
      r_count         <= '0;
      requested_floor <= '0;
      door_open       <= 1'b0;
      dir_up          <= 1'b1;
    end else begin
      case (r_state)
        WAIT, MOVE: begin
          if (w_enterDwell) begin
            door_open       <= 1'b1;
            r_count         <= '0;
            requested_floor <= current_floor;
            r_state         <= DWELL;
          end else if ((r_state == MOVE) || (|pending)) begin
            requested_floor <= w_target;
            dir_up          <= w_nextDir;
            r_state         <= MOVE;
          end else begin
            requested_floor <= current_floor;
          end
        end
        DWELL: begin
          // A fresh press at this floor keeps the door open for a full dwell.
          if (w_restart) begin
            r_count <= '0;
          end else if (w_dwellDone) begin
            door_open <= 1'b0;
            if (|pending) begin
              requested_floor <= w_target;
              dir_up          <= w_nextDir;
              r_state         <= MOVE;
            end else begin
              r_state <= WAIT;
            end
          end else begin
            r_count <= r_count + 32'd1;
          end
        end
        default: r_state <= WAIT;
      endcase
    end
  end

endmodule
